memory_access_stage: RTL and testbench
======================================

MEMORY_ACCESS_STAGE -- requirements
Module: memory_access_stage

Interface
REQ-001 Parameter WIDTH, default 22, SHALL set the datapath width; MEM_TIMEOUT, default 15, SHALL set the maximum ACCESS cycles before abort.
REQ-002 Ports SHALL be, clock and reset first:
- clk  in  1  single clock.
- rst  in  1  reset, asynchronous, active-high.
- alu_result_e  in  WIDTH  address or ALU result from execute.
- write_data_e  in  WIDTH  store data from execute.
- reg_write_m_in, mem_write_m_in, mem_to_reg_m_in, pc_src_m_in  in  1 each  execute-side controls.
- wa3_e  in  4  destination register.
- dmem_req, dmem_we  out  1 each  memory request and write enable.
- dmem_addr, dmem_wdata  out  WIDTH each  memory address and write data.
- dmem_rdata  in  WIDTH  memory read data.
- dmem_ack  in  1  memory completion.
- alu_result_memory  out  WIDTH  EX/MEM ALU result, forwarded back to execute.
- wa3_m  out  4  EX/MEM destination register, for hazard detection.
- reg_write_mem  out  1  EX/MEM reg_write, for hazard detection.
- stall_m  out  1  freezes the fetch, decode and execute stages.
- alu_result_w, read_data_w  out  WIDTH each  MEM/WB values.
- reg_write_w, mem_to_reg_w, pc_src_w  out  1 each  MEM/WB controls.
- wa3_w  out  4  MEM/WB destination register.
- mem_error  out  1  sticky timeout flag.

Function
REQ-003 The EX/MEM register SHALL capture all execute inputs on each rising clk edge where stall_m=0, and SHALL hold them while stall_m=1.
REQ-004 mem_op SHALL equal mem_write_q OR mem_to_reg_q from the EX/MEM register.
REQ-005 The FSM SHALL have three states: IDLE, ACCESS and DONE.
- IDLE to ACCESS when mem_op=1.
- ACCESS to DONE on dmem_ack=1, or when the wait counter equals MEM_TIMEOUT.
- DONE to IDLE unconditionally.
REQ-006 stall_m SHALL equal mem_op AND (state != DONE); a non-memory op SHALL pass through with zero stall cycles.
REQ-007 dmem_req SHALL be 1 exactly when state=ACCESS.
REQ-008 dmem_addr, dmem_we and dmem_wdata SHALL come from EX/MEM and SHALL stay stable while dmem_req=1.
REQ-009 dmem_ack SHALL be ignored outside ACCESS.
REQ-010 dmem_rdata SHALL be latched on the ack cycle when mem_to_reg_q=1.
REQ-011 Minimum memory-op latency SHALL be 2 stall cycles: IDLE, then ACCESS with immediate ack, then DONE capture.
REQ-012 The 4-bit wait counter SHALL clear on entering ACCESS and increment each ACCESS cycle without ack.
REQ-013 On timeout: mem_error SHALL set to 1 and stay set until reset, latched read data SHALL be 0, and the FSM SHALL go to DONE.
REQ-014 If ack and timeout occur on the same cycle, ack SHALL win: real data is latched and mem_error is unchanged.
REQ-015 The MEM/WB register SHALL capture EX/MEM values when stall_m=0.
REQ-016 While stall_m=1, the MEM/WB register SHALL load a bubble: reg_write_w=0 and pc_src_w=0, with other fields don't-care.
REQ-017 read_data_w SHALL be the latched data for memory ops and 0 otherwise.
REQ-018 alu_result_memory, wa3_m and reg_write_mem SHALL be driven directly from EX/MEM, with no combinational path from dmem_rdata.

Reset
REQ-019 While rst=1, all registers SHALL clear asynchronously: state=IDLE, counter=0, mem_error=0, all data and control outputs 0.
REQ-020 Reset asserted during ACCESS SHALL drop dmem_req immediately, and the aborted access SHALL NOT be retried.

Structure
REQ-021 The package proc_pkg SHALL hold the state enum mem_state_t, WIDTH_DEFAULT=22 and MEM_TIMEOUT_DEFAULT=15.
REQ-022 A sub-module pipe_reg (parameterised width, enable, asynchronous clear) SHALL implement both the EX/MEM and MEM/WB registers.

Verification
REQ-023 ALU op, with alu_result_e=22'h00ABC, reg_write=1 and wa3_e=5 -> the next cycle alu_result_memory=22'h00ABC, and the following cycle alu_result_w=22'h00ABC, reg_write_w=1 and wa3_w=5; stall_m=0 throughout.
REQ-024 Load from address 22'h10, with ack on the first ACCESS cycle and dmem_rdata=22'h3FFFFF -> stall_m=1 for exactly 2 cycles, then read_data_w=22'h3FFFFF and mem_to_reg_w=1.
REQ-025 Store with ack delayed 3 cycles -> dmem_req=1 for 4 cycles, dmem_we=1 and dmem_wdata stable throughout, then reg_write_w=0.
REQ-026 Load with no ack -> timeout after 15 ACCESS cycles, then mem_error=1 and read_data_w=0; ack arriving at cycle 15 -> mem_error=0.
REQ-027 rst pulse during ACCESS -> dmem_req=0, stall_m=0 and mem_error=0 immediately; a subsequent ALU op completes normally.

Source files
------------

// File: rtl/proc_pkg.sv
// Shared definitions for the processor pipeline blocks.
//   WIDTH_DEFAULT        default datapath width
//   MEM_TIMEOUT_DEFAULT  default ACCESS cycle limit before a memory op aborts
//   WAIT_CNT_W           width of the memory wait counter
//   mem_state_t          memory access FSM states
package proc_pkg;

  localparam int WIDTH_DEFAULT       = 22;
  localparam int MEM_TIMEOUT_DEFAULT = 15;
  localparam int WAIT_CNT_W          = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } mem_state_t;

endpackage

// File: rtl/pipe_reg.sv
// Generic pipeline register with load enable and asynchronous clear.
//   clk  clock
//   rst  asynchronous active-high clear
//   en   load enable; q holds its value when low
//   d    next value
//   q    registered value
module pipe_reg #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q <= '0;
    end else if (en) begin
      q <= d;
    end
  end

endmodule

// File: rtl/memory_access_stage.sv
// Memory access stage of the pipeline: EX/MEM register, data memory
// request FSM with timeout, and MEM/WB register.
//
// Ports:
//   clk, rst                    clock, asynchronous active-high reset
//   alu_result_e, write_data_e  address / ALU result and store data from execute
//   reg_write_m_in, mem_write_m_in, mem_to_reg_m_in, pc_src_m_in, wa3_e
//                               execute-side controls and destination register
//   dmem_req, dmem_we, dmem_addr, dmem_wdata
//                               data memory request (held stable while dmem_req=1)
//   dmem_rdata, dmem_ack        data memory response
//   alu_result_memory, wa3_m, reg_write_mem
//                               EX/MEM values for forwarding and hazard detection
//   stall_m                     freezes fetch, decode and execute
//   alu_result_w, read_data_w, reg_write_w, mem_to_reg_w, pc_src_w, wa3_w
//                               MEM/WB values
//   mem_error                   sticky memory timeout flag
//
// Memory handshake: dmem_req is high for every ACCESS cycle and the request
// fields do not change while it is high. The first cycle with dmem_ack=1
// while dmem_req=1 completes the access; dmem_ack at any other time is
// ignored. If no ack arrives by the ACCESS cycle in which the wait counter
// equals MEM_TIMEOUT, the access is abandoned, read data is forced to 0
// and mem_error is set until reset.
module memory_access_stage
  import proc_pkg::*;
#(
  parameter int WIDTH       = WIDTH_DEFAULT,
  parameter int MEM_TIMEOUT = MEM_TIMEOUT_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] alu_result_e,
  input  logic [WIDTH-1:0] write_data_e,
  input  logic             reg_write_m_in,
  input  logic             mem_write_m_in,
  input  logic             mem_to_reg_m_in,
  input  logic             pc_src_m_in,
  input  logic [3:0]       wa3_e,
  output logic             dmem_req,
  output logic             dmem_we,
  output logic [WIDTH-1:0] dmem_addr,
  output logic [WIDTH-1:0] dmem_wdata,
  input  logic [WIDTH-1:0] dmem_rdata,
  input  logic             dmem_ack,
  output logic [WIDTH-1:0] alu_result_memory,
  output logic [3:0]       wa3_m,
  output logic             reg_write_mem,
  output logic             stall_m,
  output logic [WIDTH-1:0] alu_result_w,
  output logic [WIDTH-1:0] read_data_w,
  output logic             reg_write_w,
  output logic             mem_to_reg_w,
  output logic             pc_src_w,
  output logic [3:0]       wa3_w,
  output logic             mem_error
);

  // EX/MEM: alu, write data, 4 controls, wa3
  localparam int EXM_W = 2 * WIDTH + 8;
  // MEM/WB: alu, read data, 3 controls, wa3
  localparam int MWB_W = 2 * WIDTH + 7;
  localparam logic [WAIT_CNT_W-1:0] TIMEOUT_CNT = WAIT_CNT_W'(MEM_TIMEOUT);

  // EX/MEM fields
  logic [EXM_W-1:0]      exm_d;
  logic [EXM_W-1:0]      exm_q;
  logic [WIDTH-1:0]      alu_q;
  logic [WIDTH-1:0]      wdata_q;
  logic                  reg_write_q;
  logic                  mem_write_q;
  logic                  mem_to_reg_q;
  logic                  pc_src_q;
  logic [3:0]            wa3_q;
  logic                  mem_op;

  // FSM and memory response tracking; state is kept as a named signal so
  // checkers can bind to it directly.
  mem_state_t            state;
  mem_state_t            state_next;
  logic [WAIT_CNT_W-1:0] wait_cnt;
  logic                  ack_hit;
  logic                  timeout_hit;
  logic [WIDTH-1:0]      read_lat;
  logic [WIDTH-1:0]      read_sel;

  // MEM/WB
  logic [MWB_W-1:0]      mwb_d;
  logic [MWB_W-1:0]      mwb_q;

  // ---------------------------------------------------------------------
  // EX/MEM register: frozen while the stage stalls so the request fields
  // stay stable for the whole access.
  // ---------------------------------------------------------------------
  assign exm_d = {alu_result_e, write_data_e, reg_write_m_in, mem_write_m_in,
                  mem_to_reg_m_in, pc_src_m_in, wa3_e};

  pipe_reg #(.W(EXM_W)) u_ex_mem (
    .clk (clk),
    .rst (rst),
    .en  (!stall_m),
    .d   (exm_d),
    .q   (exm_q)
  );

  assign {alu_q, wdata_q, reg_write_q, mem_write_q, mem_to_reg_q,
          pc_src_q, wa3_q} = exm_q;

  assign mem_op = mem_write_q | mem_to_reg_q;

  // Forwarding / hazard outputs come straight from EX/MEM flops.
  assign alu_result_memory = alu_q;
  assign wa3_m             = wa3_q;
  assign reg_write_mem     = reg_write_q;

  assign dmem_addr  = alu_q;
  assign dmem_wdata = wdata_q;
  assign dmem_we    = mem_write_q;

  // ---------------------------------------------------------------------
  // Memory access FSM
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next  = state;
    dmem_req    = 1'b0;
    ack_hit     = 1'b0;
    timeout_hit = 1'b0;
    // DONE is the cycle the finished op leaves EX/MEM, so it does not stall.
    stall_m     = mem_op && (state != DONE);
    case (state)
      IDLE: begin
        if (mem_op) state_next = ACCESS;
      end
      ACCESS: begin
        dmem_req = 1'b1;
        // An ack in the timeout cycle still counts as a real completion.
        ack_hit     = dmem_ack;
        timeout_hit = !dmem_ack && (wait_cnt == TIMEOUT_CNT);
        if (ack_hit || timeout_hit) state_next = DONE;
      end
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Wait counter, read data latch and sticky error flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wait_cnt  <= '0;
      read_lat  <= '0;
      mem_error <= 1'b0;
    end else begin
      if (state == IDLE && mem_op) begin
        wait_cnt <= '0;
      end else if (state == ACCESS && !ack_hit && !timeout_hit) begin
        wait_cnt <= wait_cnt + 1'b1;
      end

      if (ack_hit) begin
        // Stores complete with no read data.
        read_lat <= mem_to_reg_q ? dmem_rdata : '0;
      end else if (timeout_hit) begin
        read_lat  <= '0;
        mem_error <= 1'b1;
      end
    end
  end

  // ---------------------------------------------------------------------
  // MEM/WB register: always loads; a stall cycle loads an all-zero bubble
  // so nothing is written back or redirected twice.
  // ---------------------------------------------------------------------
  assign read_sel = mem_op ? read_lat : '0;

  assign mwb_d = stall_m ? '0
                         : {alu_q, read_sel, reg_write_q, mem_to_reg_q,
                            pc_src_q, wa3_q};

  pipe_reg #(.W(MWB_W)) u_mem_wb (
    .clk (clk),
    .rst (rst),
    .en  (1'b1),
    .d   (mwb_d),
    .q   (mwb_q)
  );

  assign {alu_result_w, read_data_w, reg_write_w, mem_to_reg_w,
          pc_src_w, wa3_w} = mwb_q;

endmodule

// File: tb/tb_memory_access_stage.sv
// Directed bench for memory_access_stage (WIDTH=22, MEM_TIMEOUT=15).
module tb_memory_access_stage;

  localparam int W = 22;

  logic          clk;
  logic          rst;
  logic [W-1:0]  alu_result_e;
  logic [W-1:0]  write_data_e;
  logic          reg_write_m_in;
  logic          mem_write_m_in;
  logic          mem_to_reg_m_in;
  logic          pc_src_m_in;
  logic [3:0]    wa3_e;
  logic          dmem_req;
  logic          dmem_we;
  logic [W-1:0]  dmem_addr;
  logic [W-1:0]  dmem_wdata;
  logic [W-1:0]  dmem_rdata;
  logic          dmem_ack;
  logic [W-1:0]  alu_result_memory;
  logic [3:0]    wa3_m;
  logic          reg_write_mem;
  logic          stall_m;
  logic [W-1:0]  alu_result_w;
  logic [W-1:0]  read_data_w;
  logic          reg_write_w;
  logic          mem_to_reg_w;
  logic          pc_src_w;
  logic [3:0]    wa3_w;
  logic          mem_error;

  int total;
  int bad;

  memory_access_stage dut (
    .clk               (clk),
    .rst               (rst),
    .alu_result_e      (alu_result_e),
    .write_data_e      (write_data_e),
    .reg_write_m_in    (reg_write_m_in),
    .mem_write_m_in    (mem_write_m_in),
    .mem_to_reg_m_in   (mem_to_reg_m_in),
    .pc_src_m_in       (pc_src_m_in),
    .wa3_e             (wa3_e),
    .dmem_req          (dmem_req),
    .dmem_we           (dmem_we),
    .dmem_addr         (dmem_addr),
    .dmem_wdata        (dmem_wdata),
    .dmem_rdata        (dmem_rdata),
    .dmem_ack          (dmem_ack),
    .alu_result_memory (alu_result_memory),
    .wa3_m             (wa3_m),
    .reg_write_mem     (reg_write_mem),
    .stall_m           (stall_m),
    .alu_result_w      (alu_result_w),
    .read_data_w       (read_data_w),
    .reg_write_w       (reg_write_w),
    .mem_to_reg_w      (mem_to_reg_w),
    .pc_src_w          (pc_src_w),
    .wa3_w             (wa3_w),
    .mem_error         (mem_error)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // advance to 1 time unit after the next rising edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // ---------------- driver tasks ----------------
  task automatic idle_inputs();
    alu_result_e    = '0;
    write_data_e    = '0;
    reg_write_m_in  = 1'b0;
    mem_write_m_in  = 1'b0;
    mem_to_reg_m_in = 1'b0;
    pc_src_m_in     = 1'b0;
    wa3_e           = '0;
  endtask

  // Plays the memory: called once a memory op sits in EX/MEM. Acks on the
  // ACCESS cycle with index ack_delay (negative = never). Returns when
  // stall_m drops, with cycle counts and what the request looked like.
  task automatic drive_mem(input int ack_delay, input logic [W-1:0] rdata,
                           output int req_n, output int stall_n,
                           output bit stable, output logic we_seen,
                           output logic [W-1:0] addr_seen,
                           output logic [W-1:0] wdata_seen, output bit hung);
    req_n = 0; stall_n = 0; stable = 1'b1; hung = 1'b1;
    we_seen = 1'b0; addr_seen = '0; wdata_seen = '0;
    dmem_rdata = rdata;
    for (int c = 0; c < 40; c++) begin
      if (!stall_m) begin
        hung = 1'b0;
        break;
      end
      stall_n++;
      if (dmem_req) begin
        if (req_n == 0) begin
          we_seen = dmem_we; addr_seen = dmem_addr; wdata_seen = dmem_wdata;
        end else if (dmem_we !== we_seen || dmem_addr !== addr_seen ||
                     dmem_wdata !== wdata_seen) begin
          stable = 1'b0;
        end
        dmem_ack = (req_n == ack_delay);
        req_n++;
      end else begin
        dmem_ack = 1'b0;
      end
      step();
    end
    dmem_ack = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1; dmem_ack = 1'b0; dmem_rdata = '0;
    idle_inputs();
    step(); step();
    total++; if (dmem_req !== 1'b0) begin bad++; $display("FAIL reset_req: got %b want 0", dmem_req); end
    total++; if (stall_m !== 1'b0) begin bad++; $display("FAIL reset_stall: got %b want 0", stall_m); end
    total++; if (mem_error !== 1'b0) begin bad++; $display("FAIL reset_err: got %b want 0", mem_error); end
    total++; if ({alu_result_memory, alu_result_w, read_data_w} !== '0) begin bad++; $display("FAIL reset_data: got %h/%h/%h want 0", alu_result_memory, alu_result_w, read_data_w); end
    total++; if ({reg_write_w, mem_to_reg_w, pc_src_w, wa3_w, reg_write_mem, wa3_m} !== '0) begin bad++; $display("FAIL reset_ctrl: got %b%b%b %h %b %h want 0", reg_write_w, mem_to_reg_w, pc_src_w, wa3_w, reg_write_mem, wa3_m); end
    rst = 1'b0;
  endtask

  task automatic test_alu_op(input logic [W-1:0] val, input logic [3:0] wa);
    bit stalled;
    idle_inputs();
    alu_result_e = val; reg_write_m_in = 1'b1; wa3_e = wa;
    step();
    stalled = stall_m;
    total++; if (alu_result_memory !== val) begin bad++; $display("FAIL alu_mem: got %h want %h", alu_result_memory, val); end
    total++; if (wa3_m !== wa || reg_write_mem !== 1'b1) begin bad++; $display("FAIL alu_hazard: got wa3 %h rw %b want %h 1", wa3_m, reg_write_mem, wa); end
    idle_inputs();
    step();
    stalled = stalled | stall_m;
    total++; if (alu_result_w !== val) begin bad++; $display("FAIL alu_w: got %h want %h", alu_result_w, val); end
    total++; if (reg_write_w !== 1'b1 || wa3_w !== wa) begin bad++; $display("FAIL alu_wctl: got rw %b wa3 %h want 1 %h", reg_write_w, wa3_w, wa); end
    total++; if (stalled !== 1'b0) begin bad++; $display("FAIL alu_stall: got %b want 0", stalled); end
  endtask

  task automatic test_load_fast();
    int req_n, stall_n; bit stable, hung; logic we; logic [W-1:0] a, d;
    idle_inputs();
    alu_result_e = 22'h10; mem_to_reg_m_in = 1'b1; reg_write_m_in = 1'b1; wa3_e = 4'd3;
    step();
    idle_inputs();
    drive_mem(0, 22'h3FFFFF, req_n, stall_n, stable, we, a, d, hung);
    total++; if (hung || stall_n != 2) begin bad++; $display("FAIL load_stall_cycles: got %0d hung %0d want 2", stall_n, hung); end
    total++; if (req_n != 1 || a !== 22'h10 || we !== 1'b0) begin bad++; $display("FAIL load_req: got n=%0d addr %h we %b want 1 10 0", req_n, a, we); end
    total++; if (reg_write_w !== 1'b0) begin bad++; $display("FAIL load_bubble: got %b want 0", reg_write_w); end
    step();
    total++; if (read_data_w !== 22'h3FFFFF) begin bad++; $display("FAIL load_data: got %h want 3fffff", read_data_w); end
    total++; if (mem_to_reg_w !== 1'b1 || reg_write_w !== 1'b1 || wa3_w !== 4'd3) begin bad++; $display("FAIL load_ctl: got m2r %b rw %b wa3 %h want 1 1 3", mem_to_reg_w, reg_write_w, wa3_w); end
  endtask

  task automatic test_store_slow();
    int req_n, stall_n; bit stable, hung; logic we; logic [W-1:0] a, d;
    idle_inputs();
    alu_result_e = 22'h44; write_data_e = 22'h01234; mem_write_m_in = 1'b1; wa3_e = 4'd6;
    step();
    idle_inputs();
    drive_mem(3, 22'h2BEEF, req_n, stall_n, stable, we, a, d, hung);
    total++; if (hung || req_n != 4) begin bad++; $display("FAIL store_req_cycles: got %0d want 4", req_n); end
    total++; if (stall_n != 5) begin bad++; $display("FAIL store_stall_cycles: got %0d want 5", stall_n); end
    total++; if (!stable || we !== 1'b1 || d !== 22'h01234 || a !== 22'h44) begin bad++; $display("FAIL store_fields: got stable %0d we %b wdata %h addr %h want 1 1 01234 44", stable, we, d, a); end
    step();
    total++; if (reg_write_w !== 1'b0 || mem_error !== 1'b0) begin bad++; $display("FAIL store_wb: got rw %b err %b want 0 0", reg_write_w, mem_error); end
  endtask

  task automatic test_back_to_back();
    int req_n, stall_n; bit stable, hung; logic we; logic [W-1:0] a, d;
    idle_inputs();
    alu_result_e = 22'h2AAAA; reg_write_m_in = 1'b1; pc_src_m_in = 1'b1; wa3_e = 4'd7;
    step();
    total++; if (stall_m !== 1'b0) begin bad++; $display("FAIL b2b_alu_stall: got %b want 0", stall_m); end
    idle_inputs();
    alu_result_e = 22'h30; mem_to_reg_m_in = 1'b1; reg_write_m_in = 1'b1; wa3_e = 4'd4;
    step();
    total++; if (pc_src_w !== 1'b1 || alu_result_w !== 22'h2AAAA || wa3_w !== 4'd7) begin bad++; $display("FAIL b2b_alu_wb: got pc %b alu %h wa3 %h want 1 2aaaa 7", pc_src_w, alu_result_w, wa3_w); end
    total++; if (stall_m !== 1'b1) begin bad++; $display("FAIL b2b_load_stall: got %b want 1", stall_m); end
    idle_inputs();
    step();
    total++; if (pc_src_w !== 1'b0 || reg_write_w !== 1'b0) begin bad++; $display("FAIL b2b_bubble: got pc %b rw %b want 0 0", pc_src_w, reg_write_w); end
    drive_mem(0, 22'h15555, req_n, stall_n, stable, we, a, d, hung);
    total++; if (hung || req_n != 1 || a !== 22'h30) begin bad++; $display("FAIL b2b_req: got n=%0d addr %h want 1 30", req_n, a); end
    step();
    total++; if (read_data_w !== 22'h15555 || wa3_w !== 4'd4) begin bad++; $display("FAIL b2b_load_wb: got %h wa3 %h want 15555 4", read_data_w, wa3_w); end
  endtask

  task automatic test_timeout();
    int req_n, stall_n; bit stable, hung; logic we; logic [W-1:0] a, d;
    idle_inputs();
    alu_result_e = 22'h88; mem_to_reg_m_in = 1'b1; reg_write_m_in = 1'b1; wa3_e = 4'd2;
    step();
    idle_inputs();
    drive_mem(-1, 22'h3FFFFF, req_n, stall_n, stable, we, a, d, hung);
    // counter runs 0..15 over the ACCESS cycles, abort on the one where it equals 15
    total++; if (hung || req_n != 16) begin bad++; $display("FAIL timeout_req_cycles: got %0d hung %0d want 16", req_n, hung); end
    total++; if (mem_error !== 1'b1) begin bad++; $display("FAIL timeout_err: got %b want 1", mem_error); end
    step();
    total++; if (read_data_w !== '0 || mem_to_reg_w !== 1'b1) begin bad++; $display("FAIL timeout_data: got %h m2r %b want 0 1", read_data_w, mem_to_reg_w); end
    test_alu_op(22'h00777, 4'd1);
    total++; if (mem_error !== 1'b1) begin bad++; $display("FAIL timeout_sticky: got %b want 1", mem_error); end
  endtask

  task automatic test_reset_during_access();
    bit req_seen;
    idle_inputs();
    alu_result_e = 22'h99; mem_to_reg_m_in = 1'b1; reg_write_m_in = 1'b1; wa3_e = 4'd8;
    step();
    idle_inputs();
    step();
    total++; if (dmem_req !== 1'b1) begin bad++; $display("FAIL rst_pre_req: got %b want 1", dmem_req); end
    #2 rst = 1'b1;
    #1;
    total++; if (dmem_req !== 1'b0 || stall_m !== 1'b0) begin bad++; $display("FAIL rst_async: got req %b stall %b want 0 0", dmem_req, stall_m); end
    total++; if (mem_error !== 1'b0) begin bad++; $display("FAIL rst_err: got %b want 0", mem_error); end
    step();
    rst = 1'b0;
    req_seen = 1'b0;
    for (int i = 0; i < 4; i++) begin
      req_seen = req_seen | dmem_req | stall_m;
      step();
    end
    total++; if (req_seen !== 1'b0) begin bad++; $display("FAIL rst_no_retry: got %b want 0", req_seen); end
    test_alu_op(22'h00155, 4'd9);
  endtask

  task automatic test_ack_at_timeout();
    int req_n, stall_n; bit stable, hung; logic we; logic [W-1:0] a, d;
    idle_inputs();
    alu_result_e = 22'h20; mem_to_reg_m_in = 1'b1; reg_write_m_in = 1'b1; wa3_e = 4'd5;
    step();
    idle_inputs();
    drive_mem(15, 22'h2A5A5, req_n, stall_n, stable, we, a, d, hung);
    total++; if (hung || req_n != 16 || !stable) begin bad++; $display("FAIL ackto_req: got n=%0d stable %0d want 16 1", req_n, stable); end
    total++; if (mem_error !== 1'b0) begin bad++; $display("FAIL ackto_err: got %b want 0", mem_error); end
    step();
    total++; if (read_data_w !== 22'h2A5A5) begin bad++; $display("FAIL ackto_data: got %h want 2a5a5", read_data_w); end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    total = 0;
    bad   = 0;
    test_reset();
    test_alu_op(22'h00ABC, 4'd5);
    test_load_fast();
    test_store_slow();
    test_back_to_back();
    test_timeout();
    test_reset_during_access();
    test_ack_at_timeout();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
